// File: rtl/imul_var_pkg.sv
// Shared types for the variable-latency iterative multiplier: FSM states,
// datapath control word and datapath status word.
package imul_var_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   // a/b register input select
   localparam logic SEL_SHIFT = 1'b0;
   localparam logic SEL_REQ   = 1'b1;

   // result register input select
   localparam logic RES_SEL_ADD  = 1'b0;
   localparam logic RES_SEL_ZERO = 1'b1;

   // add mux: keep running sum or take sum + a
   localparam logic ADD_SEL_HOLD = 1'b0;
   localparam logic ADD_SEL_SUM  = 1'b1;

   // shift distance select
   localparam logic SHIFT_BY_1 = 1'b0;
   localparam logic SHIFT_BY_4 = 1'b1;

   typedef struct packed {
      logic a_mux_sel;
      logic b_mux_sel;
      logic result_mux_sel;
      logic add_mux_sel;
      logic a_en;
      logic b_en;
      logic result_en;
      logic skip_sel;
   } cs_t;

   typedef struct packed {
      logic b_lsb;
      logic b_zero;
      logic b_next_zero;
      logic b_low4_zero;
   } ss_t;

   function automatic cs_t cs_idle();
      cs_t c;
      c = '0;
      return c;
   endfunction

endpackage

// File: rtl/imul_var_iter_dpath.sv
// Datapath of imul_var_iter: operand/result registers, shifters, adder and
// input muxes, steered by the control word from the top-level FSM.
module imul_var_iter_dpath
   import imul_var_pkg::*;
#(
   parameter int unsigned NBITS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  cs_t              i_cs,
   input  logic [NBITS-1:0] i_req_a,
   input  logic [NBITS-1:0] i_req_b,
   output ss_t              o_ss,
   output logic [NBITS-1:0] o_result
);

   localparam logic [NBITS-1:0] LOW4_MASK = NBITS'(15);

   logic [NBITS-1:0] r_a;
   logic [NBITS-1:0] r_b;
   logic [NBITS-1:0] r_result;

   logic [NBITS-1:0] w_a_shift;
   logic [NBITS-1:0] w_b_shift;
   logic [NBITS-1:0] w_sum;
   logic [NBITS-1:0] w_add_out;
   logic [NBITS-1:0] w_a_next;
   logic [NBITS-1:0] w_b_next;
   logic [NBITS-1:0] w_result_next;

   always_comb begin
      w_a_shift = (i_cs.skip_sel == SHIFT_BY_4) ? (r_a << 4) : (r_a << 1);
      w_b_shift = (i_cs.skip_sel == SHIFT_BY_4) ? (r_b >> 4) : (r_b >> 1);
      // Overflow beyond NBITS is discarded by the register width.
      w_sum     = r_result + r_a;
      w_add_out = (i_cs.add_mux_sel == ADD_SEL_SUM) ? w_sum : r_result;

      w_a_next      = (i_cs.a_mux_sel == SEL_REQ) ? i_req_a : w_a_shift;
      w_b_next      = (i_cs.b_mux_sel == SEL_REQ) ? i_req_b : w_b_shift;
      w_result_next = (i_cs.result_mux_sel == RES_SEL_ZERO) ? '0 : w_add_out;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
      end else begin
         if (i_cs.a_en)      r_a      <= w_a_next;
         if (i_cs.b_en)      r_b      <= w_b_next;
         if (i_cs.result_en) r_result <= w_result_next;
      end
   end

   always_comb begin
      o_ss             = '0;
      o_ss.b_lsb       = r_b[0];
      o_ss.b_zero      = (r_b == '0);
      o_ss.b_next_zero = ((r_b >> 1) == '0);
      o_ss.b_low4_zero = ((r_b & LOW4_MASK) == '0);
   end

   assign o_result = r_result;

endmodule

// File: rtl/imul_var_iter.sv
// Variable-latency iterative shift-add multiplier with val/rdy handshakes.
// Define IMUL_VAR_ZERO_SKIP_EN to skip four zero multiplier bits per cycle.
module imul_var_iter
   import imul_var_pkg::*;
#(
   parameter int unsigned NBITS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_val,
   output logic             req_rdy,
   input  logic [NBITS-1:0] req_a,
   input  logic [NBITS-1:0] req_b,
   output logic             resp_val,
   input  logic             resp_rdy,
   output logic [NBITS-1:0] resp_result
);

`ifdef IMUL_VAR_ZERO_SKIP_EN
   localparam logic SKIP_EN = 1'b1;
`else
   localparam logic SKIP_EN = 1'b0;
`endif

   state_e r_state;
   logic   r_req_rdy;
   logic   r_resp_val;

   cs_t  w_cs;
   ss_t  w_ss;
   logic w_req_go;
   logic w_resp_go;
   logic w_skip;

   assign w_req_go  = req_val && r_req_rdy;
   assign w_resp_go = r_resp_val && resp_rdy;
   // A nibble skip never empties b (b != 0 with low four bits clear).
   assign w_skip    = SKIP_EN && !w_ss.b_zero && w_ss.b_low4_zero;

   always_comb begin
      w_cs = cs_idle();
      case (r_state)
         IDLE: begin
            if (w_req_go) begin
               w_cs.a_mux_sel      = SEL_REQ;
               w_cs.b_mux_sel      = SEL_REQ;
               w_cs.result_mux_sel = RES_SEL_ZERO;
               w_cs.a_en           = 1'b1;
               w_cs.b_en           = 1'b1;
               w_cs.result_en      = 1'b1;
            end
         end
         CALC: begin
            if (w_skip) begin
               w_cs.skip_sel = SHIFT_BY_4;
               w_cs.a_en     = 1'b1;
               w_cs.b_en     = 1'b1;
            end else if (!w_ss.b_zero) begin
               w_cs.skip_sel       = SHIFT_BY_1;
               w_cs.add_mux_sel    = ADD_SEL_SUM;
               w_cs.result_mux_sel = RES_SEL_ADD;
               w_cs.a_en           = 1'b1;
               w_cs.b_en           = 1'b1;
               w_cs.result_en      = w_ss.b_lsb;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_req_rdy  <= 1'b1;
         r_resp_val <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req_go) begin
                  r_state   <= CALC;
                  r_req_rdy <= 1'b0;
               end
            end
            CALC: begin
               if (w_ss.b_zero || (!w_skip && w_ss.b_next_zero)) begin
                  r_state    <= DONE;
                  r_resp_val <= 1'b1;
               end
            end
            DONE: begin
               if (w_resp_go) begin
                  r_state    <= IDLE;
                  r_req_rdy  <= 1'b1;
                  r_resp_val <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_req_rdy  <= 1'b1;
               r_resp_val <= 1'b0;
            end
         endcase
      end
   end

   imul_var_iter_dpath #(
      .NBITS (NBITS)
   ) u_dpath (
      .clk      (clk),
      .reset    (reset),
      .i_cs     (w_cs),
      .i_req_a  (req_a),
      .i_req_b  (req_b),
      .o_ss     (w_ss),
      .o_result (resp_result)
   );

   assign req_rdy  = r_req_rdy;
   assign resp_val = r_resp_val;

endmodule

// File: tb/tb_imul_var_iter.sv
// Self-checking bench for imul_var_iter: directed cases plus random operands
// against a plain-arithmetic model of product and latency.
module tb_imul_var_iter;

   localparam int unsigned NBITS = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_val;
   logic             req_rdy;
   logic [NBITS-1:0] req_a;
   logic [NBITS-1:0] req_b;
   logic             resp_val;
   logic             resp_rdy;
   logic [NBITS-1:0] resp_result;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   imul_var_iter #(
      .NBITS (NBITS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_val     (req_val),
      .req_rdy     (req_rdy),
      .req_a       (req_a),
      .req_b       (req_b),
      .resp_val    (resp_val),
      .resp_rdy    (resp_rdy),
      .resp_result (resp_result)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NBITS-1:0] ref_product(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      return p[NBITS-1:0];
   endfunction

   // Cycle (req_go = cycle 0) in which resp_val first rises.
   function automatic int unsigned ref_latency(input logic [NBITS-1:0] b);
      int unsigned steps;
      logic [NBITS-1:0] bb;
      bb = b;
      steps = 0;
      while (bb != 0) begin
`ifdef IMUL_VAR_ZERO_SKIP_EN
         if ((bb % 16) == 0) bb = bb / 16;
         else                bb = bb / 2;
`else
         bb = bb / 2;
`endif
         steps++;
      end
      if (steps == 0) steps = 1;
      return steps + 1;
   endfunction

   task automatic run_op(input string tag, input logic [NBITS-1:0] a,
                         input logic [NBITS-1:0] b, input int unsigned hold);
      int unsigned cyc;
      bit          seen;
      bit          rdy_low;
      bit          stable;
      logic [NBITS-1:0] first;

      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (req_rdy) seen = 1;
      end
      if (!seen) begin
         chk({tag, "_idle_timeout"}, 64'd0, 64'd1);
         return;
      end

      req_a    = a;
      req_b    = b;
      req_val  = 1'b1;
      resp_rdy = (hold == 0);
      @(negedge clk);
      req_val = 1'b0;
      req_a   = $urandom;
      req_b   = $urandom;

      cyc     = 1;
      seen    = 0;
      rdy_low = 1;
      while (!seen && cyc < NBITS + 8) begin
         if (resp_val) seen = 1;
         else begin
            if (req_rdy) rdy_low = 0;
            @(negedge clk);
            cyc++;
            if (hold != 0) resp_rdy = $urandom_range(0, 1) == 1 ? 1'b0 : 1'b0;
         end
      end
      if (!seen) begin
         chk({tag, "_resp_timeout"}, 64'd0, 64'd1);
         return;
      end
      if (req_rdy) rdy_low = 0;
      chk({tag, "_latency"}, 64'(cyc), 64'(ref_latency(b)));
      chk({tag, "_result"}, 64'(resp_result), 64'(ref_product(a, b)));

      if (hold != 0) begin
         first  = resp_result;
         stable = 1;
         for (int h = 0; h < int'(hold); h++) begin
            @(negedge clk);
            if (resp_result !== first || resp_val !== 1'b1) stable = 0;
            if (req_rdy) rdy_low = 0;
         end
         chk({tag, "_hold_stable"}, 64'(stable), 64'd1);
         resp_rdy = 1'b1;
      end
      chk({tag, "_req_rdy_low"}, 64'(rdy_low), 64'd1);
      @(negedge clk);
      chk({tag, "_back_idle"}, {62'd0, req_rdy, resp_val}, 64'b10);
   endtask

   initial begin
      logic [NBITS-1:0] ra;
      logic [NBITS-1:0] rb;
      bit               quiet;

      reset    = 1'b1;
      req_val  = 1'b0;
      req_a    = '0;
      req_b    = '0;
      resp_rdy = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", {62'd0, req_rdy, resp_val}, 64'b10);
      chk("reset_result", 64'(resp_result), 64'd0);
      reset = 1'b0;

      run_op("basic", 32'd3, 32'd5, 0);
      run_op("zero_b", 32'h1234, 32'd0, 0);
      run_op("signed", 32'hFFFF_FFFD, 32'd7, 0);
      run_op("overflow", 32'h8000_0000, 32'd2, 0);
      run_op("sparse", 32'd9, 32'h100, 0);
      run_op("backpress", 32'd6, 32'd7, 5);
      run_op("max_b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("top_bit", 32'd1, 32'h8000_0000, 1);

      // Reset while CALC is busy: the dropped op must never respond.
      @(negedge clk);
      req_a   = 32'd5;
      req_b   = 32'hFFFF_FFFF;
      req_val = 1'b1;
      resp_rdy = 1'b1;
      @(negedge clk);
      req_val = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset_state", {62'd0, req_rdy, resp_val}, 64'b10);
      chk("midreset_result", 64'(resp_result), 64'd0);
      quiet = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (resp_val) quiet = 0;
      end
      chk("midreset_no_resp", 64'(quiet), 64'd1);
      run_op("after_reset", 32'd2, 32'd3, 0);

      for (int n = 0; n < 40; n++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 7) == 0) rb = '0;
         if ($urandom_range(0, 5) == 0) rb = rb << $urandom_range(4, 12);
         run_op("random", ra, rb, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
